// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver with a single-entry holding register (valid/ready) and
// decode of the capture command byte into a one-cycle pulse.
module uart_rx_cmd #(
    parameter int          CLK_FREQ = 50_000_000,
    parameter int          BAUD     = 115200,
    parameter logic [7:0]  CMD_CAP  = 8'h43
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       cmd_capture,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr
);

    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_cap;
    logic             r_ferr;
    logic             r_ovr;

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign cmd_capture = r_cap;
    assign frame_err   = r_ferr;
    assign overrun     = r_ovr;

    // Later assignments in this block override earlier ones: a byte completing
    // beats the handshake clear, and a flag set beats err_clr.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_cap     <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
            r_cap     <= 1'b0;

            if (err_clr) begin
                r_ferr <= 1'b0;
                r_ovr  <= 1'b0;
            end
            if (r_valid && rx_ready)
                r_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_rx_prev && !r_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_bit   <= '0;
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_bit] <= r_rx_s;
                        if (r_bit == 3'd7)
                            r_state <= S_STOP;
                        else
                            r_bit <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            if (!r_valid || rx_ready) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                            r_cap <= (r_shift == CMD_CAP);
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // No new start bit is accepted until the line returns high.
                    if (r_rx_s)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed + randomized bench for uart_rx_cmd; a frame-level model tracks the
// holding register, sticky flags and the expected number of capture pulses.
module tb_uart_rx_cmd;

    localparam int CPB = 50_000_000 / 115200;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       cmd_capture;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;

    uart_rx_cmd #(
        .CLK_FREQ (50_000_000),
        .BAUD     (115200),
        .CMD_CAP  (8'h43)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cmd_capture (cmd_capture),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .err_clr     (err_clr)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Observation counters, sampled on the falling edge.
    int cyc        = 0;
    int cap_cnt    = 0;
    int ferr_cyc   = 0;
    int cap_cyc    = -1;
    int vrise_cyc  = -1;
    logic prev_v   = 1'b0;

    always @(negedge CLOCK_50) begin
        cyc <= cyc + 1;
        if (cmd_capture) begin
            cap_cnt <= cap_cnt + 1;
            cap_cyc <= cyc;
        end
        if (frame_err)
            ferr_cyc <= ferr_cyc + 1;
        if (rx_valid && !prev_v)
            vrise_cyc <= cyc;
        prev_v <= rx_valid;
    end

    // Reference model state.
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovr;
    logic       m_ferr;
    int         m_caps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"},   {31'd0, rx_valid},  {31'd0, m_valid});
        chk({tag, "_data"},    {24'd0, rx_data},   {24'd0, m_data});
        chk({tag, "_overrun"}, {31'd0, overrun},   {31'd0, m_ovr});
        chk({tag, "_ferr"},    {31'd0, frame_err}, {31'd0, m_ferr});
        chk({tag, "_caps"},    cap_cnt,            m_caps);
    endtask

    // Consumer is held not-ready during frames, so a good byte lands only if empty.
    task automatic model_good(input logic [7:0] b);
        if (!m_valid) begin
            m_data  = b;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        if (b == 8'h43)
            m_caps++;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge CLOCK_50);
        rx_ready = 1'b0;
        @(negedge CLOCK_50);
        m_valid = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge CLOCK_50);
        err_clr = 1'b0;
        @(negedge CLOCK_50);
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge CLOCK_50);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge CLOCK_50);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge CLOCK_50);
        rx = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    int         t0;
    int         lat;
    int         snap;
    logic [7:0] rb;

    initial begin
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_ovr    = 1'b0;
        m_ferr   = 1'b0;
        m_caps   = 0;
        repeat (5) @(negedge CLOCK_50);
        check_model("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge CLOCK_50);

        // Plain byte with latency bound.
        t0 = cyc;
        send(8'hA5, 1'b1);
        model_good(8'hA5);
        check_model("a5");
        lat = vrise_cyc - t0;
        chk("a5_latency_ok", {31'd0, (lat >= 4120 && lat <= 4345)}, 32'd1);
        consume();

        // Command byte: single-cycle pulse coincident with rx_valid rising.
        snap = cap_cnt;
        send(8'h43, 1'b1);
        model_good(8'h43);
        check_model("c43");
        chk("c43_pulse_len", cap_cnt - snap, 32'd1);
        chk("c43_same_cycle", cap_cyc, vrise_cyc);
        consume();

        // Overrun: second byte dropped while holding register is full.
        send(8'h11, 1'b1);
        model_good(8'h11);
        send(8'h22, 1'b1);
        model_good(8'h22);
        check_model("overrun");
        clear_err();
        check_model("overrun_clr");

        // Framing error, then a long break, then recovery.
        send(8'h55, 1'b0);
        m_ferr = 1'b1;
        check_model("ferr");
        clear_err();
        rx = 1'b0;
        repeat (30 * CPB) @(negedge CLOCK_50);
        rx = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        m_ferr = 1'b1;
        check_model("break");
        clear_err();
        consume();
        send(8'h3C, 1'b1);
        model_good(8'h3C);
        check_model("c3c");

        // Flag set wins over err_clr held through the stop sample.
        snap = ferr_cyc;
        err_clr = 1'b1;
        send(8'h43, 1'b0);
        err_clr = 1'b0;
        @(negedge CLOCK_50);
        chk("ferr_set_priority_cycles", ferr_cyc - snap, 32'd1);
        check_model("after_clr_frame");

        // Short low glitch on the idle line is a false start.
        consume();
        rx = 1'b0;
        repeat (100) @(negedge CLOCK_50);
        rx = 1'b1;
        repeat (600) @(negedge CLOCK_50);
        check_model("glitch");

        // Randomized bytes with random draining.
        for (int n = 0; n < 3; n++) begin
            if ($urandom_range(0, 1) == 1)
                consume();
            rb = 8'($urandom);
            send(rb, 1'b1);
            model_good(rb);
            check_model($sformatf("rand%0d_%02h", n, rb));
        end

        // Reset during data bit 4 aborts the frame.
        rx = 1'b0;
        repeat (CPB) @(negedge CLOCK_50);
        for (int i = 0; i < 5; i++) begin
            rx = i[0];
            repeat ((i == 4) ? CPB / 2 : CPB) @(negedge CLOCK_50);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        rst_n = 1'b1;
        repeat (CPB * 2) @(negedge CLOCK_50);
        check_model("midreset");
        send(8'h7E, 1'b1);
        model_good(8'h7E);
        check_model("c7e");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
